// File: rtl/mem_arb_pkg.sv
// Shared encodings for the DataMemory arbiter: FSM states and requester port indices.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic P_MEM = 1'b0;
   localparam logic P_AUX = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way grant selection: round-robin against the last winner, or fixed priority to port 0.
module rr_arbiter2
   import mem_arb_pkg::*;
#(
   parameter int FAIR = 1
)(
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic any,
   output logic g
);

   always_comb begin
      any = req0 | req1;
      g   = P_MEM;
      if (req0 && req1) begin
         g = (FAIR != 0) ? ~last_grant : P_MEM;
      end else if (req1) begin
         g = P_AUX;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port DataMemory between the MEM stage (port 0) and a secondary master
// (port 1); each access is a fixed-length strobe window followed by a one-cycle ack.
module data_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int WORD          = 32,
   parameter int ADDRESSL      = 32,
   parameter int LENGTH        = 4000,
   parameter int ACCESS_CYCLES = 1,
   parameter int FAIR          = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                req0,
   input  logic                req1,
   input  logic                we0,
   input  logic                we1,
   input  logic [ADDRESSL-1:0] addr0,
   input  logic [ADDRESSL-1:0] addr1,
   input  logic [WORD-1:0]     wdata0,
   input  logic [WORD-1:0]     wdata1,
   output logic                ack0,
   output logic                ack1,
   output logic                err0,
   output logic                err1,
   output logic [WORD-1:0]     rdata0,
   output logic [WORD-1:0]     rdata1,
   output logic                stall0,
   output logic [ADDRESSL-1:0] mem_address,
   output logic [WORD-1:0]     mem_writeData,
   output logic                mem_memRead,
   output logic                mem_memWrite,
   input  logic [WORD-1:0]     mem_readData,
   output logic [1:0]          dbg_state
);

   localparam int                CW       = $clog2(ACCESS_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_INIT = CW'(ACCESS_CYCLES - 1);
   localparam logic [ADDRESSL-1:0] LIMIT  = ADDRESSL'(LENGTH);

   // Handshake: a requester raises req with we/addr/wdata stable and keeps it high until
   // the one-cycle ack for that port; requests are only sampled while the FSM is in IDLE.
   state_t                state, state_nxt;
   logic                  last_grant;
   logic [CW-1:0]         cnt;
   logic                  cmd_g, cmd_we, cmd_err;
   logic                  any, g;
   logic [ADDRESSL-1:0]   sel_addr;
   logic [WORD-1:0]       sel_wdata;
   logic                  sel_we;
   logic                  in_range;

   rr_arbiter2 #(.FAIR(FAIR)) u_arb (
      .req0       (req0),
      .req1       (req1),
      .last_grant (last_grant),
      .any        (any),
      .g          (g)
   );

   assign sel_addr  = (g == P_AUX) ? addr1  : addr0;
   assign sel_wdata = (g == P_AUX) ? wdata1 : wdata0;
   assign sel_we    = (g == P_AUX) ? we1    : we0;
   assign in_range  = (sel_addr < LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         last_grant    <= P_AUX;
         cnt           <= '0;
         cmd_g         <= P_MEM;
         cmd_we        <= 1'b0;
         cmd_err       <= 1'b0;
         mem_address   <= '0;
         mem_writeData <= '0;
         rdata0        <= '0;
         rdata1        <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (any) begin
                  cmd_g   <= g;
                  cmd_we  <= sel_we;
                  cmd_err <= ~in_range;
                  cnt     <= CNT_INIT;
                  // Out-of-range requests leave the memory pins untouched.
                  if (in_range) begin
                     mem_address   <= sel_addr;
                     mem_writeData <= sel_wdata;
                  end
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (!cmd_we) begin
                     if (cmd_g == P_AUX) rdata1 <= mem_readData;
                     else                rdata0 <= mem_readData;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            DONE: begin
               last_grant <= cmd_g;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt    = state;
      mem_memRead  = 1'b0;
      mem_memWrite = 1'b0;
      ack0         = 1'b0;
      ack1         = 1'b0;
      err0         = 1'b0;
      err1         = 1'b0;
      case (state)
         IDLE: begin
            if (any) state_nxt = in_range ? ACCESS : DONE;
         end
         ACCESS: begin
            mem_memRead  = ~cmd_we;
            mem_memWrite = cmd_we;
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            ack0      = (cmd_g == P_MEM);
            ack1      = (cmd_g == P_AUX);
            err0      = (cmd_g == P_MEM) & cmd_err;
            err1      = (cmd_g == P_AUX) & cmd_err;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign stall0    = req0 & ~ack0;
   assign dbg_state = state;

endmodule
